// File: rtl/rv32_pkg.sv
// Shared RV32I fetch-stage types, constants and the B-type immediate decoder.
package rv32_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [6:0]      OPCODE_BRANCH = 7'b1100011;
  localparam logic [XLEN-1:0] NOP_INSTR     = 32'h0000_0013;

  typedef enum logic [0:0] {
    RUN    = 1'b0,
    BUBBLE = 1'b1
  } fetch_state_e;

  // IF/ID boundary payload
  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
    logic            misalign;
    logic            pred_taken;
  } if_id_beat_t;

  // Sign-extended B-type immediate (bit 0 is always zero)
  function automatic logic [XLEN-1:0] imm_b(input logic [XLEN-1:0] instr);
    logic unused_bits;
    unused_bits = ^{instr[24:12], instr[6:0]};
    return {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  endfunction

endpackage

// File: rtl/if_btfn_predictor.sv
// Static backward-taken/forward-not-taken predictor for the word being fetched.
module if_btfn_predictor
  import rv32_pkg::*;
(
  input  logic [XLEN-1:0] instr_i,
  input  logic [XLEN-1:0] pc_i,
  output logic            taken_c,
  output logic [XLEN-1:0] target_c
);

  logic [XLEN-1:0] imm_c;

  // Only backward conditional branches are predicted taken
  always_comb begin
    imm_c    = imm_b(instr_i);
    taken_c  = (instr_i[6:0] == OPCODE_BRANCH) && imm_c[XLEN-1];
    target_c = taken_c ? (pc_i + imm_c) : (pc_i + XLEN'(4));
  end

endmodule

// File: rtl/if_fetch_stage.sv
// RV32I instruction-fetch stage: PC, IF/ID register, decode handshake and EX redirect.
// Optional static prediction is enabled by defining IF_BTFN_PREDICT_EN.
module if_fetch_stage
  import rv32_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC  = 32'h0000_0000,
  parameter logic [XLEN-1:0] NOP_INSTR = rv32_pkg::NOP_INSTR
) (
  input  logic            clk,
  input  logic            rst,
  output logic [XLEN-1:0] i_mem_addr,
  input  logic [XLEN-1:0] i_mem_rdata,
  output logic            id_valid,
  input  logic            id_ready,
  output logic [XLEN-1:0] id_instr,
  output logic [XLEN-1:0] id_pc,
  output logic            id_misalign,
  output logic            id_pred_taken,
  input  logic            ex_redirect,
  input  logic [XLEN-1:0] ex_target,
  output logic [XLEN-1:0] fetch_count
);

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            valid_q, valid_d;
  if_id_beat_t     beat_q, beat_d;
  logic            mis_pend_q, mis_pend_d;
  logic [XLEN-1:0] fetch_count_q, fetch_count_d;

  logic            advance_c;
  logic            pred_taken_c;
  logic [XLEN-1:0] next_pc_c;

`ifdef IF_BTFN_PREDICT_EN
  if_btfn_predictor u_btfn_predictor (
    .instr_i  (i_mem_rdata),
    .pc_i     (pc_q),
    .taken_c  (pred_taken_c),
    .target_c (next_pc_c)
  );
`else
  assign pred_taken_c = 1'b0;
  assign next_pc_c    = pc_q + XLEN'(4);
`endif

  assign advance_c = !valid_q || id_ready;

  // FSM next state: a redirect always (re)starts the bubble
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RUN:     if (ex_redirect) state_d = BUBBLE;
      BUBBLE:  state_d = ex_redirect ? BUBBLE : RUN;
      default: state_d = RUN;
    endcase
  end

  // Datapath next state: redirect > advance > hold
  always_comb begin
    pc_d          = pc_q;
    valid_d       = valid_q;
    beat_d        = beat_q;
    mis_pend_d    = mis_pend_q;
    fetch_count_d = fetch_count_q;

    if (valid_q && id_ready && !ex_redirect) begin
      fetch_count_d = fetch_count_q + XLEN'(1);
    end

    if (ex_redirect) begin
      pc_d              = {ex_target[XLEN-1:2], 2'b00};
      mis_pend_d        = (ex_target[1:0] != 2'b00);
      valid_d           = 1'b0;
      beat_d.instr      = NOP_INSTR;
      beat_d.misalign   = 1'b0;
      beat_d.pred_taken = 1'b0;
    end else if (advance_c) begin
      pc_d              = next_pc_c;
      mis_pend_d        = 1'b0;
      valid_d           = 1'b1;
      beat_d.instr      = i_mem_rdata;
      beat_d.pc         = pc_q;
      beat_d.misalign   = mis_pend_q;
      beat_d.pred_taken = pred_taken_c;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= RUN;
      pc_q          <= RESET_PC;
      valid_q       <= 1'b0;
      beat_q        <= '{instr: NOP_INSTR, pc: '0, misalign: 1'b0, pred_taken: 1'b0};
      mis_pend_q    <= 1'b0;
      fetch_count_q <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      valid_q       <= valid_d;
      beat_q        <= beat_d;
      mis_pend_q    <= mis_pend_d;
      fetch_count_q <= fetch_count_d;
    end
  end

  assign i_mem_addr    = pc_q;
  assign id_valid      = valid_q;
  assign id_instr      = beat_q.instr;
  assign id_pc         = beat_q.pc;
  assign id_misalign   = beat_q.misalign;
  assign id_pred_taken = beat_q.pred_taken;
  assign fetch_count   = fetch_count_q;

endmodule

// File: tb/tb_if_fetch_stage.sv
// Self-checking bench for if_fetch_stage: scoreboard of accepted beats plus per-scenario checks.
module tb_if_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;
`ifdef IF_BTFN_PREDICT_EN
  localparam bit PRED_ON = 1'b1;
`else
  localparam bit PRED_ON = 1'b0;
`endif

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        mis;
    logic        pred;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] i_mem_addr;
  logic [31:0] i_mem_rdata;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic        id_misalign;
  logic        id_pred_taken;
  logic        ex_redirect;
  logic [31:0] ex_target;
  logic [31:0] fetch_count;

  beat_t       sb[$];
  int          n_pass  = 0;
  int          n_total = 0;
  logic [31:0] exp_fc  = '0;

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0000_0000: return 32'h0050_0093;
      32'h0000_0004: return 32'h00A0_0113;
      32'h0000_0020: return 32'hFE00_0EE3;
      default:       return {a[24:0], 7'h13};
    endcase
  endfunction

  assign i_mem_rdata = mem_word(i_mem_addr);

  if_fetch_stage dut (
    .clk           (clk),
    .rst           (rst),
    .i_mem_addr    (i_mem_addr),
    .i_mem_rdata   (i_mem_rdata),
    .id_valid      (id_valid),
    .id_ready      (id_ready),
    .id_instr      (id_instr),
    .id_pc         (id_pc),
    .id_misalign   (id_misalign),
    .id_pred_taken (id_pred_taken),
    .ex_redirect   (ex_redirect),
    .ex_target     (ex_target),
    .fetch_count   (fetch_count)
  );

  function automatic beat_t mk(input logic [31:0] pc, input logic mis, input logic pred);
    beat_t b;
    b.instr = mem_word(pc);
    b.pc    = pc;
    b.mis   = mis;
    b.pred  = pred;
    return b;
  endfunction

  // Advance one clock; a beat handed over at this edge is popped and compared
  task automatic clock_cycle();
    beat_t e;
    if (id_valid && id_ready && !ex_redirect && !rst) begin
      n_total++;
      if (sb.size() == 0) begin
        $display("FAIL sb_underflow: unexpected beat pc=%h instr=%h", id_pc, id_instr);
      end else begin
        e = sb.pop_front();
        if (id_instr !== e.instr || id_pc !== e.pc || id_misalign !== e.mis || id_pred_taken !== e.pred)
          $display("FAIL sb_beat: got pc=%h instr=%h mis=%b pred=%b, want pc=%h instr=%h mis=%b pred=%b",
                   id_pc, id_instr, id_misalign, id_pred_taken, e.pc, e.instr, e.mis, e.pred);
        else n_pass++;
      end
      exp_fc = exp_fc + 32'd1;
    end
    if (rst) exp_fc = '0;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; id_ready = 1'b1; ex_redirect = 1'b0; ex_target = '0;
    clock_cycle();
    clock_cycle();
    n_total++;
    if (id_valid !== 1'b0 || id_instr !== NOP || id_pc !== 32'h0 || id_misalign !== 1'b0 ||
        id_pred_taken !== 1'b0 || fetch_count !== 32'h0 || i_mem_addr !== 32'h0)
      $display("FAIL reset_state: got v=%b instr=%h pc=%h mis=%b pred=%b fc=%h addr=%h, want 0/%h/0/0/0/0/0",
               id_valid, id_instr, id_pc, id_misalign, id_pred_taken, fetch_count, i_mem_addr, NOP);
    else n_pass++;
  endtask

  task automatic test_stream();
    rst = 1'b0;
    clock_cycle();
    n_total++;
    if (id_valid !== 1'b1 || id_pc !== 32'h0 || id_instr !== 32'h0050_0093 || i_mem_addr !== 32'h4)
      $display("FAIL stream_first: got v=%b pc=%h instr=%h addr=%h, want 1/0/00500093/4",
               id_valid, id_pc, id_instr, i_mem_addr);
    else n_pass++;
    sb.push_back(mk(32'h0, 1'b0, 1'b0));
    clock_cycle();
    n_total++;
    if (id_pc !== 32'h4 || id_instr !== 32'h00A0_0113 || i_mem_addr !== 32'h8)
      $display("FAIL stream_second: got pc=%h instr=%h addr=%h, want 4/00a00113/8", id_pc, id_instr, i_mem_addr);
    else n_pass++;
    sb.push_back(mk(32'h4, 1'b0, 1'b0));
    clock_cycle();
    n_total++;
    if (fetch_count !== 32'd2 || fetch_count !== exp_fc)
      $display("FAIL stream_count: got %0d want 2", fetch_count);
    else n_pass++;
  endtask

  task automatic test_stall();
    id_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      clock_cycle();
      n_total++;
      if (id_valid !== 1'b1 || i_mem_addr !== 32'hC || id_pc !== 32'h8 || id_instr !== mem_word(32'h8) ||
          fetch_count !== 32'd2)
        $display("FAIL stall_hold%0d: got v=%b addr=%h pc=%h instr=%h fc=%0d, want 1/c/8/%h/2",
                 i, id_valid, i_mem_addr, id_pc, id_instr, fetch_count, mem_word(32'h8));
      else n_pass++;
    end
    id_ready = 1'b1;
    sb.push_back(mk(32'h8, 1'b0, 1'b0));
    clock_cycle();
    n_total++;
    if (id_pc !== 32'hC || i_mem_addr !== 32'h10 || fetch_count !== 32'd3)
      $display("FAIL stall_resume: got pc=%h addr=%h fc=%0d, want c/10/3", id_pc, i_mem_addr, fetch_count);
    else n_pass++;
  endtask

  task automatic test_redirect();
    ex_redirect = 1'b1; ex_target = 32'h40;
    clock_cycle();
    n_total++;
    if (id_valid !== 1'b0 || i_mem_addr !== 32'h40 || fetch_count !== 32'd3)
      $display("FAIL redirect_bubble: got v=%b addr=%h fc=%0d, want 0/40/3", id_valid, i_mem_addr, fetch_count);
    else n_pass++;
    ex_redirect = 1'b0;
    clock_cycle();
    n_total++;
    if (id_valid !== 1'b1 || id_pc !== 32'h40 || id_misalign !== 1'b0 || i_mem_addr !== 32'h44)
      $display("FAIL redirect_target: got v=%b pc=%h mis=%b addr=%h, want 1/40/0/44",
               id_valid, id_pc, id_misalign, i_mem_addr);
    else n_pass++;
    sb.push_back(mk(32'h40, 1'b0, 1'b0));
    clock_cycle();
  endtask

  task automatic test_misalign();
    ex_redirect = 1'b1; ex_target = 32'h42;
    clock_cycle();
    n_total++;
    if (id_valid !== 1'b0 || i_mem_addr !== 32'h40)
      $display("FAIL misalign_bubble: got v=%b addr=%h, want 0/40", id_valid, i_mem_addr);
    else n_pass++;
    ex_redirect = 1'b0;
    clock_cycle();
    sb.push_back(mk(32'h40, 1'b1, 1'b0));
    clock_cycle();
    n_total++;
    if (id_pc !== 32'h44 || id_misalign !== 1'b0)
      $display("FAIL misalign_clear: got pc=%h mis=%b, want 44/0", id_pc, id_misalign);
    else n_pass++;
    sb.push_back(mk(32'h44, 1'b0, 1'b0));
    clock_cycle();
  endtask

  task automatic test_back_to_back();
    ex_redirect = 1'b1; ex_target = 32'h80;
    clock_cycle();
    ex_target = 32'h100;
    clock_cycle();
    n_total++;
    if (id_valid !== 1'b0 || i_mem_addr !== 32'h100)
      $display("FAIL b2b_last_wins: got v=%b addr=%h, want 0/100", id_valid, i_mem_addr);
    else n_pass++;
    ex_redirect = 1'b0;
    clock_cycle();
    id_ready = 1'b0;
    clock_cycle();
    n_total++;
    if (id_valid !== 1'b1 || id_pc !== 32'h100)
      $display("FAIL b2b_target: got v=%b pc=%h, want 1/100", id_valid, id_pc);
    else n_pass++;
    ex_redirect = 1'b1; ex_target = 32'h200;
    clock_cycle();
    n_total++;
    if (id_valid !== 1'b0 || i_mem_addr !== 32'h200 || fetch_count !== exp_fc)
      $display("FAIL stall_redirect: got v=%b addr=%h fc=%0d, want 0/200/%0d",
               id_valid, i_mem_addr, fetch_count, exp_fc);
    else n_pass++;
    ex_redirect = 1'b0; id_ready = 1'b1;
    clock_cycle();
    n_total++;
    if (id_pc !== 32'h200 || id_valid !== 1'b1)
      $display("FAIL stall_redirect_target: got pc=%h v=%b, want 200/1", id_pc, id_valid);
    else n_pass++;
    sb.push_back(mk(32'h200, 1'b0, 1'b0));
    clock_cycle();
  endtask

  task automatic test_wrap();
    ex_redirect = 1'b1; ex_target = 32'hFFFF_FFFC;
    clock_cycle();
    ex_redirect = 1'b0;
    clock_cycle();
    n_total++;
    if (id_pc !== 32'hFFFF_FFFC || i_mem_addr !== 32'h0)
      $display("FAIL pc_wrap: got pc=%h addr=%h, want fffffffc/0", id_pc, i_mem_addr);
    else n_pass++;
    sb.push_back(mk(32'hFFFF_FFFC, 1'b0, 1'b0));
    clock_cycle();
    n_total++;
    if (id_pc !== 32'h0 || i_mem_addr !== 32'h4)
      $display("FAIL pc_wrap_next: got pc=%h addr=%h, want 0/4", id_pc, i_mem_addr);
    else n_pass++;
  endtask

  task automatic test_predict();
    logic [31:0] exp_next;
    exp_next = PRED_ON ? 32'h1C : 32'h24;
    ex_redirect = 1'b1; ex_target = 32'h20;
    clock_cycle();
    ex_redirect = 1'b0;
    clock_cycle();
    n_total++;
    if (id_pc !== 32'h20 || id_instr !== 32'hFE00_0EE3 || id_pred_taken !== PRED_ON || i_mem_addr !== exp_next)
      $display("FAIL predict_branch: got pc=%h instr=%h pred=%b addr=%h, want 20/fe000ee3/%b/%h",
               id_pc, id_instr, id_pred_taken, i_mem_addr, PRED_ON, exp_next);
    else n_pass++;
    sb.push_back(mk(32'h20, 1'b0, PRED_ON));
    clock_cycle();
    n_total++;
    if (id_pc !== exp_next || id_pred_taken !== 1'b0)
      $display("FAIL predict_follow: got pc=%h pred=%b, want %h/0", id_pc, id_pred_taken, exp_next);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    id_ready = 1'b0;
    clock_cycle();
    rst = 1'b1; ex_redirect = 1'b1; ex_target = 32'h300;
    clock_cycle();
    n_total++;
    if (id_valid !== 1'b0 || id_instr !== NOP || id_pc !== 32'h0 || id_misalign !== 1'b0 ||
        id_pred_taken !== 1'b0 || fetch_count !== 32'h0 || i_mem_addr !== 32'h0)
      $display("FAIL reset_mid: got v=%b instr=%h pc=%h mis=%b pred=%b fc=%h addr=%h, want 0/%h/0/0/0/0/0",
               id_valid, id_instr, id_pc, id_misalign, id_pred_taken, fetch_count, i_mem_addr, NOP);
    else n_pass++;
    rst = 1'b0; ex_redirect = 1'b0; id_ready = 1'b1;
    clock_cycle();
    n_total++;
    if (id_pc !== 32'h0 || id_instr !== 32'h0050_0093 || id_valid !== 1'b1)
      $display("FAIL reset_mid_restart: got pc=%h instr=%h v=%b, want 0/00500093/1", id_pc, id_instr, id_valid);
    else n_pass++;
  endtask

  initial begin
    rst = 1'b1; id_ready = 1'b1; ex_redirect = 1'b0; ex_target = '0;
    @(negedge clk);
    test_reset();
    test_stream();
    test_stall();
    test_redirect();
    test_misalign();
    test_back_to_back();
    test_wrap();
    test_predict();
    test_reset_mid();
    n_total++;
    if (sb.size() != 0)
      $display("FAIL sb_drain: got %0d beats left, want 0", sb.size());
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/if_fetch_stage.md
Name: if_fetch_stage

Overview:
Instruction-fetch stage of the RV32I pipeline; owns the PC and drives the instruction-memory port (i_mem_addr out, i_mem_rdata in, combinational read).
- Registers each fetched word with its PC into the IF/ID boundary.
- Hands instructions to decode over a valid/ready handshake.
- Accepts branch/jump redirects from EX and flushes the in-flight slot.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset.
NOP_INSTR, 32'h0000_0013, value on id_instr when no valid instruction (ADDI x0,x0,0).

Ports:
clk  in  1  single clock, all state updates on rising edge
rst  in  1  synchronous, active-high reset
i_mem_addr  out  32  byte address of word being fetched; equals pc, bits[1:0] always 0
i_mem_rdata  in  32  instruction word at i_mem_addr, valid same cycle
id_valid  out  1  id_instr/id_pc hold a valid instruction
id_ready  in  1  decode accepts the current beat
id_instr  out  32  fetched instruction
id_pc  out  32  address of id_instr
id_misalign  out  1  beat is the first fetch after a redirect whose target[1:0]!=0
id_pred_taken  out  1  static-prediction tag (0 when feature compiled out)
ex_redirect  in  1  EX resolved a taken branch/jump
ex_target  in  32  redirect target byte address
fetch_count  out  32  number of beats accepted by decode

Behaviour:
- Reset (rst=1 at edge): pc=RESET_PC, id_valid=0, id_instr=NOP_INSTR, id_pc=0, id_misalign=0, id_pred_taken=0, fetch_count=0, mis_pend=0, state=RUN.
- i_mem_addr = pc, combinational.
- advance = !id_valid || id_ready.
- Priority at each edge: rst > ex_redirect > advance > hold.
- ex_redirect=1:
  - pc <= {ex_target[31:2],2'b00}; mis_pend <= (ex_target[1:0]!=0).
  - id_valid <= 0 and id_instr <= NOP_INSTR, regardless of id_ready; the killed beat is not counted.
  - state <= BUBBLE.
- advance && !ex_redirect:
  - id_instr <= i_mem_rdata; id_pc <= pc; id_valid <= 1; id_misalign <= mis_pend; mis_pend <= 0.
  - pc <= pc+4, modulo 2^32 (0xFFFF_FFFC -> 0).
  - state <= RUN.
- Otherwise (id_valid && !id_ready): hold pc and all id_* outputs stable.
- fetch_count increments, modulo 2^32, on every edge where id_valid && id_ready && !ex_redirect.
- FSM:
  - RUN: normal streaming.
  - BUBBLE: the one cycle after a redirect; id_valid=0 and the target is being fetched. BUBBLE -> RUN on the next edge unless a new redirect arrives.
  - Redirect-to-visible latency: redirect sampled at edge N, target beat on id_* after edge N+1 (one bubble).
- Back-to-back redirects: the last one wins; each restarts BUBBLE.
- Redirect during a decode stall: stall is overridden and the held beat is discarded.
- Reset mid-stream: all state returns to reset values at that edge; ex_redirect is ignored.

Optional Feature:
Macro IF_BTFN_PREDICT_EN.
- Defined: when a fetched word is B-type (opcode 7'b1100011) with negative immediate, the beat is tagged id_pred_taken=1 and pc <= pc + sext(imm_b) instead of pc+4.
- EX must redirect to pc+4 on mispredict; the redirect path is unchanged.
- Not defined: id_pred_taken is tied 0 and pc always advances by 4.

Decomposition:
- Shared package rv32_pkg: OPCODE_BRANCH, NOP_INSTR, XLEN=32, fetch-state enum {RUN, BUBBLE}, imm_b extraction function.
- One natural sub-module, if_btfn_predictor: combinational B-immediate decode plus taken decision. It is instantiated only under IF_BTFN_PREDICT_EN.

Test Plan:
- Reset release, id_ready=1, memory holding words 0x00500093, 0x00A00113 -> i_mem_addr goes 0x0, 0x4, 0x8; id_pc 0x0 then 0x4 with matching id_instr; fetch_count=2 after two beats.
- Hold id_ready=0 for 3 cycles with id_valid=1 -> pc, id_instr and id_pc stable; fetch_count unchanged; streaming resumes at the next address when id_ready=1.
- ex_redirect=1, ex_target=0x40 at pc=0x10 -> next cycle id_valid=0 and i_mem_addr=0x40; the following cycle id_pc=0x40; the killed beat is not counted.
- ex_target=0x42 -> fetch from 0x40 with id_misalign=1 on that beat only; next beat id_misalign=0.
- pc=0xFFFF_FFFC, advance -> next i_mem_addr=0x0; also assert rst during a stall -> all outputs return to reset values on that edge.
- Feature on: word 0xFE000EE3 (BEQ x0,x0,-4) at 0x20 -> id_pred_taken=1 and next i_mem_addr=0x1C. Feature off -> id_pred_taken=0 and next i_mem_addr=0x24.
